matrix_key_scan: RTL and testbench



---
 rtl/matrix_key_pkg.sv | 18 +
 rtl/matrix_key_debounce.sv | 60 ++++++
 rtl/matrix_key_scan.sv | 98 +++++++++
 tb/tb_matrix_key_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_key_pkg.sv
// Shared constants and types for the 4x4 matrix key scanner.
// Optional build macro: MATRIX_KEY_SCAN_COL_SYNC_EN (column synchronizer).
package matrix_key_pkg;

    localparam int MK_ROWS = 4;
    localparam int MK_COLS = 4;
    localparam int MK_KEYS = 16;

    typedef logic [1:0] row_idx_t;

    localparam logic [MK_ROWS-1:0] ROW_DRIVE [MK_ROWS] = '{
        4'b1110,
        4'b1101,
        4'b1011,
        4'b0111
    };

endpackage

// File: rtl/matrix_key_debounce.sv
// Frame-level debounce: key follows the frame vector once it has
// matched the previous frame DEBOUNCE_CNT times in a row.
module matrix_key_debounce
    import matrix_key_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MK_KEYS-1:0] frame_i,
    input  logic               strobe_i,
    output logic [MK_KEYS-1:0] key_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W:0] CNT_MAX = (CNT_W + 1)'(DEBOUNCE_CNT);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     cnt_p1;
    logic [MK_KEYS-1:0] prev_q, prev_d;
    logic [MK_KEYS-1:0] key_q, key_d;
    logic               match;

    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        key_d  = key_q;
        cnt_p1 = {1'b0, cnt_q} + 1'b1;
        match  = (frame_i == prev_q);
        if (strobe_i) begin
            prev_d = frame_i;
            if (match) begin
                // Saturate so a long-held key never wraps the counter.
                if (cnt_p1 >= CNT_MAX) begin
                    cnt_d = CNT_MAX[CNT_W-1:0];
                    key_d = frame_i;
                end else begin
                    cnt_d = cnt_p1[CNT_W-1:0];
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            prev_q <= '0;
            key_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            key_q  <= key_d;
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 key matrix scanner: one-cold row drive, end-of-slot column sampling.
// Define MATRIX_KEY_SCAN_COL_SYNC_EN to add a 2-flop column synchronizer.
module matrix_key_scan
    import matrix_key_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MK_COLS-1:0] col,
    output logic [MK_ROWS-1:0] row,
    output logic [MK_KEYS-1:0] key,
    output logic               frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    row_idx_t           idx_q, idx_d;
    logic [MK_ROWS-1:0] row_q, row_d;
    logic [MK_KEYS-1:0] snap_q, snap_d;
    logic [MK_KEYS-1:0] frame_vec;
    logic               fd_q;
    logic               sample;
    logic               frame_end;
    logic [MK_COLS-1:0] col_s;

`ifdef MATRIX_KEY_SCAN_COL_SYNC_EN
    logic [MK_COLS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
        end
    end

    assign col_s = sync2_q;
`else
    assign col_s = col;
`endif

    assign sample    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (idx_q == row_idx_t'(MK_ROWS - 1));

    // frame_vec already holds the current row's columns, so on the last
    // row it is the complete frame handed to the debouncer.
    always_comb begin
        frame_vec = snap_q;
        frame_vec[{idx_q, 2'b00} +: MK_COLS] = ~col_s;
    end

    always_comb begin
        div_d  = div_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (sample) begin
            div_d  = '0;
            idx_d  = idx_q + 1'b1;
            snap_d = frame_vec;
        end
        row_d = ROW_DRIVE[idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            idx_q  <= '0;
            row_q  <= ROW_DRIVE[0];
            snap_q <= '0;
            fd_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            row_q  <= row_d;
            snap_q <= snap_d;
            fd_q   <= frame_end;
        end
    end

    matrix_key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .frame_i (frame_vec),
        .strobe_i(frame_end),
        .key_o   (key)
    );

    assign row        = row_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Randomized and directed bench for matrix_key_scan against a frame-history model.
module tb_matrix_key_scan;

    localparam int SD = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key;
    logic        frame_done;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;

    int          n;
    logic [15:0] m_snap;
    logic [15:0] m_key;
    logic        m_fd;
    logic [15:0] frames[$];
    logic [15:0] phist[$];

    always #5 clk = ~clk;

    matrix_key_scan #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key       (key),
        .frame_done(frame_done)
    );

    // Physical matrix: a pressed key shorts its column to the driven row.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    // Key updates when the last DB+1 frames (reset counts as a zero frame)
    // are all identical.
    task automatic model_edge();
        logic [15:0] ps;
        int          r;
        bit          same;
        if (rst) begin
            n = 0;
            m_snap = '0;
            m_key = '0;
            m_fd = 1'b0;
            frames = {};
            frames.push_back(16'h0);
            phist = {};
            return;
        end
        phist.push_back(pressed);
`ifdef MATRIX_KEY_SCAN_COL_SYNC_EN
        ps = (phist.size() >= 3) ? phist[phist.size()-3] : 16'h0;
`else
        ps = pressed;
`endif
        if (phist.size() > 8) void'(phist.pop_front());
        m_fd = 1'b0;
        if (n % SD == SD - 1) begin
            r = (n / SD) % 4;
            m_snap[r*4 +: 4] = ps[r*4 +: 4];
            if (r == 3) begin
                m_fd = 1'b1;
                frames.push_back(m_snap);
                if (frames.size() > DB + 1) void'(frames.pop_front());
                if (frames.size() == DB + 1) begin
                    same = 1'b1;
                    foreach (frames[i]) if (frames[i] != m_snap) same = 1'b0;
                    if (same) m_key = m_snap;
                end
            end
        end
        n++;
    endtask

    task automatic tick();
        logic [3:0] erow;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        erow = 4'hF;
        erow[rst ? 0 : (n / SD) % 4] = 1'b0;
        chk("row", 32'(row), 32'(erow));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("key", 32'(key), 32'(m_key));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(3);
        chk("rst_row", 32'(row), 32'h0000_000E);
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        n = 0;
        m_snap = '0;
        m_key = '0;
        m_fd = 1'b0;
        frames = {16'h0};
        @(negedge clk);

        // Reset, then single press of (1,2) held from before frame 0.
        pressed = 16'h0040;
        do_reset();
        ticks(16);
        chk("fd_step", 32'(frame_done), 32'h1);
        ticks(31);
        chk("press_early", 32'(key), 32'h0);
        tick();
        chk("press_key", 32'(key), 32'h0040);
        pressed = 16'h0000;
        ticks(32);
        chk("release_hold", 32'(key), 32'h0040);
        ticks(16);
        chk("release_key", 32'(key), 32'h0);

        // Bounce on (0,0) over alternate frames, then steady.
        do_reset();
        for (int f = 0; f < 6; f++) begin
            pressed = (f % 2 == 0) ? 16'h0001 : 16'h0000;
            ticks(16);
            chk("bounce_hold", 32'(key), 32'h0);
        end
        pressed = 16'h0001;
        ticks(32);
        chk("steady_early", 32'(key), 32'h0);
        ticks(16);
        chk("steady_key", 32'(key), 32'h0001);

        // Row 3 and row 0 together: last row must land before the compare.
        do_reset();
        pressed = 16'h8008;
        ticks(48);
        chk("multi_key", 32'(key), 32'h8008);

        // Reset in the middle of row 2.
        pressed = 16'h0040;
        do_reset();
        ticks(48);
        chk("mid_pre", 32'(key), 32'h0040);
        for (int i = 0; i < 16 && (n % 16) != 10; i++) tick();
        chk("mid_phase", 32'(n % 16), 32'd10);
        rst = 1'b1;
        tick();
        chk("mid_key", 32'(key), 32'h0);
        chk("mid_row", 32'(row), 32'h0000_000E);
        rst = 1'b0;
        ticks(47);
        chk("mid_early", 32'(key), 32'h0);
        tick();
        chk("mid_back", 32'(key), 32'h0040);

        // Random presses and bounces at arbitrary cycle positions.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0)
                pressed[$urandom_range(15)] ^= 1'b1;
            if ($urandom_range(199) == 0)
                pressed = 16'($urandom);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            pressed = 16'($urandom);
            ticks(80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 n_errors);
        $finish;
    end

endmodule
